// File: rtl/dec3to8_hs_if.sv
// Handshake bundle for the registered 3-to-8 decoder.
// The producer side carries the code and the consumer side carries the decoded lines.
interface dec3to8_hs_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_y;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_d;

  modport master (
    output in_valid, in_y, in_en, out_ready,
    input  in_ready, out_valid, out_d
  );

  modport slave (
    input  in_valid, in_y, in_en, out_ready,
    output in_ready, out_valid, out_d
  );
endinterface

// File: rtl/dec3to8_hs.sv
// Registered 3-to-8 one-hot decoder with a 2-entry elastic buffer.
// Entry 0 is always the head. Decode is purely from the head, so the only
// paths from the input side to the outputs go through flops.
module dec3to8_hs #(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dec3to8_hs_if.slave      bus,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    logic       en;
    logic [2:0] code;
  } ent_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e             occ, occ_nxt;
  ent_t             ent0, ent1, ent0_nxt, ent1_nxt, in_ent;
  logic [CNT_W-1:0] cnt_nxt;
  logic             acc, pop;
  logic [7:0]       hot;

  assign bus.in_ready  = (occ != FULL);
  assign bus.out_valid = (occ != EMPTY);
  assign acc           = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign in_ent.en     = bus.in_en;
  assign in_ent.code   = bus.in_y;

  // State, buffer entries and delivery counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= EMPTY;
      ent0      <= '0;
      ent1      <= '0;
      dec_count <= '0;
    end else begin
      occ       <= occ_nxt;
      ent0      <= ent0_nxt;
      ent1      <= ent1_nxt;
      dec_count <= cnt_nxt;
    end
  end

  // Occupancy transitions and buffer movement; input data is only sampled on accept,
  // so an X on in_y/in_en while in_valid is low never reaches the entries.
  always_comb begin
    occ_nxt  = occ;
    ent0_nxt = ent0;
    ent1_nxt = ent1;
    cnt_nxt  = dec_count;
    if (pop && ent0.en) cnt_nxt = dec_count + CNT_W'(1);
    case (occ)
      EMPTY: begin
        if (acc) begin
          occ_nxt  = ONE;
          ent0_nxt = in_ent;
        end
      end
      ONE: begin
        if (acc && pop) begin
          ent0_nxt = in_ent;
        end else if (acc) begin
          occ_nxt  = FULL;
          ent1_nxt = in_ent;
        end else if (pop) begin
          occ_nxt  = EMPTY;
          ent0_nxt = '0;
        end
      end
      FULL: begin
        if (pop) begin
          occ_nxt  = ONE;
          ent0_nxt = ent1;
          ent1_nxt = '0;
        end
      end
      default: begin
        occ_nxt  = EMPTY;
        ent0_nxt = '0;
        ent1_nxt = '0;
      end
    endcase
  end

  // One lane per output line: active when the valid head is enabled and carries its code
  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign hot[k] = bus.out_valid & ent0.en & (ent0.code == 3'(k));
  end

  assign bus.out_d = OUT_ACTIVE_LOW ? ~hot : hot;

endmodule

// File: tb/tb_dec3to8_hs.sv
// Bench for dec3to8_hs: three instances (default, active-low, 2-bit counter)
// share one stimulus stream and are checked against a queue-based model.
module tb_dec3to8_hs;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_y;
  logic       in_en;
  logic       out_ready;
  logic [7:0] cnt0;
  logic [7:0] cnt_lo;
  logic [1:0] cnt2;

  dec3to8_hs_if b0 ();
  dec3to8_hs_if b1 ();
  dec3to8_hs_if b2 ();

  assign b0.in_valid = in_valid;  assign b0.in_y = in_y;  assign b0.in_en = in_en;  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;  assign b1.in_y = in_y;  assign b1.in_en = in_en;  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;  assign b2.in_y = in_y;  assign b2.in_en = in_en;  assign b2.out_ready = out_ready;

  dec3to8_hs #(.OUT_ACTIVE_LOW(1'b0), .CNT_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b0), .dec_count(cnt0));
  dec3to8_hs #(.OUT_ACTIVE_LOW(1'b1), .CNT_W(8)) u_lo  (.clk(clk), .rst_n(rst_n), .bus(b1), .dec_count(cnt_lo));
  dec3to8_hs #(.OUT_ACTIVE_LOW(1'b0), .CNT_W(2)) u_c2  (.clk(clk), .rst_n(rst_n), .bus(b2), .dec_count(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: FIFO of accepted codes plus an unbounded delivery count
  typedef struct {
    logic       en;
    logic [2:0] code;
  } ment_t;

  ment_t q[$];
  int    mcnt;
  int    tests;
  int    fails;

  function automatic logic [7:0] exp_d();
    if (q.size() == 0) return 8'h00;
    if (!q[0].en) return 8'h00;
    return 8'(1 << q[0].code);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] d;
    logic [7:0] dl;
    d  = exp_d();
    dl = ~d;
    chk("out_valid",    32'(b0.out_valid), 32'(q.size() != 0));
    chk("in_ready",     32'(b0.in_ready),  32'(q.size() != 2));
    chk("out_d",        32'(b0.out_d),     32'(d));
    chk("out_valid_lo", 32'(b1.out_valid), 32'(q.size() != 0));
    chk("out_d_lo",     32'(b1.out_d),     32'(dl));
    chk("in_ready_c2",  32'(b2.in_ready),  32'(q.size() != 2));
    chk("dec_count",    32'(cnt0),         32'(mcnt % 256));
    chk("dec_count_lo", 32'(cnt_lo),       32'(mcnt % 256));
    chk("dec_count_c2", 32'(cnt2),         32'(mcnt % 4));
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the model at the rising edge
  task automatic cyc(input logic v, input logic [2:0] y, input logic e, input logic r);
    logic acc;
    logic pop;
    in_valid  = v;
    in_y      = v ? y : 3'bxxx;
    in_en     = v ? e : 1'bx;
    out_ready = r;
    #1;
    check_all();
    acc = v && (q.size() < 2);
    pop = r && (q.size() > 0);
    @(posedge clk);
    if (pop) begin
      if (q[0].en) mcnt++;
      void'(q.pop_front());
    end
    if (acc) q.push_back('{en: e, code: y});
    @(negedge clk);
  endtask

  initial begin
    int base;
    tests     = 0;
    fails     = 0;
    mcnt      = 0;
    in_valid  = 1'b0;
    in_y      = 3'd0;
    in_en     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #3 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all();
    chk("reset_idle_lo", 32'(b1.out_d), 32'h0000_00FF);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming codes 0..7 with the consumer always ready
    for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), 1'b1, 1'b1);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("stream_count", 32'(cnt0), 32'd8);

    // Back-pressure: fill to two entries, third push stalls
    cyc(1'b1, 3'd3, 1'b1, 1'b0);
    cyc(1'b1, 3'd6, 1'b1, 1'b0);
    chk("full_in_ready", 32'(b0.in_ready), 32'd0);
    chk("full_hold_d",   32'(b0.out_d),    32'h08);
    cyc(1'b1, 3'd2, 1'b1, 1'b0);
    chk("stall_hold_d",  32'(b0.out_d),    32'h08);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("drain_1st_d",   32'(b0.out_d),    32'h40);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("drain_ready",   32'(b0.in_ready), 32'd1);

    // Accept and pop together while holding one entry
    cyc(1'b1, 3'd1, 1'b1, 1'b0);
    cyc(1'b1, 3'd5, 1'b1, 1'b1);
    chk("one_swap_d",     32'(b0.out_d),     32'h20);
    chk("one_swap_ready", 32'(b0.in_ready),  32'd1);
    chk("one_swap_valid", 32'(b0.out_valid), 32'd1);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);

    // Disabled entry: valid with no active line, not counted
    base = mcnt;
    cyc(1'b1, 3'd7, 1'b0, 1'b0);
    chk("en0_valid", 32'(b0.out_valid), 32'd1);
    chk("en0_d",     32'(b0.out_d),     32'h00);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("en0_count", 32'(cnt0), 32'(base % 256));

    // Asynchronous reset while full
    cyc(1'b1, 3'd3, 1'b1, 1'b0);
    cyc(1'b1, 3'd6, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(b0.out_valid), 32'd0);
    chk("arst_ready",  32'(b0.in_ready),  32'd1);
    chk("arst_count",  32'(cnt0),         32'd0);
    chk("arst_d",      32'(b0.out_d),     32'h00);
    chk("arst_d_lo",   32'(b1.out_d),     32'hFF);
    chk("arst_cnt_c2", 32'(cnt2),         32'd0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Active-low decode of code 2, then five enabled pops to wrap the 2-bit counter
    cyc(1'b1, 3'd2, 1'b1, 1'b1);
    chk("lo_code2", 32'(b1.out_d), 32'hFB);
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'(k + 4), 1'b1, 1'b1);
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("wrap_c2",  32'(cnt2), 32'd1);
    chk("count_5",  32'(cnt0), 32'd5);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
